// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: state encoding,
// requester count/index width and the round-robin winner search.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Scanning from lowest to highest priority lets the highest-priority hit
  // overwrite earlier ones; the last-granted index itself is checked first.
  function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                       input logic [IDX_W-1:0]   last);
    rr_pick_t         pick;
    logic [IDX_W-1:0] cand;
    pick = '{found: 1'b0, idx: {IDX_W{1'b0}}};
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last + IDX_W'(k);
      pick = req[cand] ? '{found: 1'b1, idx: cand} : pick;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_4_to_1.sv
// Plain 4:1 single-bit data multiplexer used as the shared output line.
module mux_4_to_1
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_d,
  input  logic [IDX_W-1:0]   i_sel,
  output logic               o_y
);

  // Select one data bit by binary index.
  always_comb begin
    case (i_sel)
      2'd0:    o_y = i_d[0];
      2'd1:    o_y = i_d[1];
      2'd2:    o_y = i_d[2];
      2'd3:    o_y = i_d[3];
      default: o_y = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter with bounded bursts; the granted
// requester's data bit is routed combinationally onto o_y.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
)
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_data,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_sel,
  output logic               o_valid,
  output logic               o_y
);

  // Counter value seen on the edge that ends the MAX_BURST-th grant cycle.
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  arb_state_e         state_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic [IDX_W-1:0]   sel_r;
  logic               valid_r;
  logic [IDX_W-1:0]   last_r;
  logic [CNT_W-1:0]   cnt_r;
  rr_pick_t           pick_s;
  logic               hold_s;
  logic               mux_y_s;

  // Next round-robin winner and whether the current owner keeps the line.
  always_comb begin
    pick_s = rr_pick(i_req, last_r);
    if (state_r == GRANT) begin
      hold_s = i_req[sel_r] && (cnt_r < BURST_LAST);
    end else begin
      hold_s = 1'b0;
    end
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      gnt_r   <= 4'b0000;
      sel_r   <= 2'b00;
      valid_r <= 1'b0;
      last_r  <= 2'b11;
      cnt_r   <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_s.found) begin
            state_r <= GRANT;
            gnt_r   <= 4'b0001 << pick_s.idx;
            sel_r   <= pick_s.idx;
            valid_r <= 1'b1;
            last_r  <= pick_s.idx;
            cnt_r   <= 4'd0;
          end else begin
            state_r <= IDLE;
            gnt_r   <= 4'b0000;
            valid_r <= 1'b0;
            cnt_r   <= 4'd0;
          end
        end
        GRANT: begin
          if (hold_s) begin
            cnt_r <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 4'd1;
          end else if (pick_s.found) begin
            // Release and re-arbitrate on the same edge: no idle bubble.
            state_r <= GRANT;
            gnt_r   <= 4'b0001 << pick_s.idx;
            sel_r   <= pick_s.idx;
            valid_r <= 1'b1;
            last_r  <= pick_s.idx;
            cnt_r   <= 4'd0;
          end else begin
            state_r <= IDLE;
            gnt_r   <= 4'b0000;
            valid_r <= 1'b0;
            cnt_r   <= 4'd0;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= 4'b0000;
          valid_r <= 1'b0;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  mux_4_to_1 u_mux (
    .i_d   (i_data),
    .i_sel (sel_r),
    .o_y   (mux_y_s)
  );

  assign o_gnt   = gnt_r;
  assign o_sel   = sel_r;
  assign o_valid = valid_r;
  assign o_y     = mux_y_s & valid_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a queue-based reference model predicts
// each cycle's grant outputs; a negedge monitor pops and compares them.
module tb_mux_rr_arbiter;

  localparam int MB = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] data;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       y;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];
  int   tests   = 0;
  int   fails   = 0;
  bit   started = 1'b0;

  // Reference model state: owner (-1 = nobody), cycles owned, pointer, last sel.
  int owner  = -1;
  int held   = 0;
  int last   = 3;
  int sel_m  = 0;

  mux_rr_arbiter #(.MAX_BURST(MB)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_data  (data),
    .o_gnt   (gnt),
    .o_sel   (sel),
    .o_valid (valid),
    .o_y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.gnt   = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
    e.sel   = sel_m[1:0];
    e.valid = (owner >= 0);
    return e;
  endfunction

  function automatic void model_reset();
    owner = -1;
    held  = 0;
    last  = 3;
    sel_m = 0;
  endfunction

  function automatic void model_step(input logic [3:0] r);
    int nxt;
    if (owner >= 0 && r[owner] && held < MB) begin
      held++;
    end else begin
      nxt = -1;
      for (int k = 1; k <= 4; k++) begin
        if (nxt < 0 && r[(last + k) % 4]) nxt = (last + k) % 4;
      end
      owner = nxt;
      if (nxt >= 0) begin
        held  = 1;
        last  = nxt;
        sel_m = nxt;
      end
    end
  endfunction

  // Drive one cycle of inputs (just after a posedge), then predict the next state.
  task automatic step(input logic [3:0] r);
    req  = r;
    data = 4'($urandom_range(0, 15));
    @(posedge clk);
    if (rst_n) model_step(r);
    else model_reset();
    exp_q.push_back(model_out());
    started = 1'b1;
    #2;
  endtask

  // Assert reset mid-cycle, check the asynchronous drop, hold for n cycles.
  task automatic do_reset(input int n);
    exp_t z;
    z = '{gnt: 4'b0000, sel: 2'b00, valid: 1'b0};
    rst_n = 1'b0;
    model_reset();
    if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = z;
    #1;
    chk("async_rst_gnt",   int'(gnt),   0);
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_y",     int'(y),     0);
    for (int i = 0; i < n; i++) step(4'($urandom_range(0, 15)));
    rst_n = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the oldest prediction every negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        if (exp_q.size() == 0) begin
          chk("queue_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("gnt",   int'(gnt),   int'(e.gnt));
          chk("sel",   int'(sel),   int'(e.sel));
          chk("valid", int'(valid), int'(e.valid));
          chk("y",     int'(y),     e.valid ? int'(data[e.sel]) : 0);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    data  = 4'b0000;
    #2;
    do_reset(3);
    // Single request from reset.
    for (int i = 0; i < 5; i++) step(4'b0100);
    do_reset(2);
    // Fairness with all requesting.
    for (int i = 0; i < 22; i++) step(4'b1111);
    do_reset(2);
    // Early release of requester 1 handing over to 3.
    step(4'b0010);
    step(4'b0010);
    for (int i = 0; i < 4; i++) step(4'b1000);
    do_reset(2);
    // Sole requester 3 re-granted across burst boundaries.
    for (int i = 0; i < 10; i++) step(4'b1000);
    do_reset(2);
    // Reset in the middle of a grant to 2, then all request.
    for (int i = 0; i < 3; i++) step(4'b0100);
    do_reset(2);
    for (int i = 0; i < 6; i++) step(4'b1111);
    // Idle with data toggling.
    for (int i = 0; i < 8; i++) step(4'b0000);
    // Random traffic with occasional mid-run resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset(1);
      step(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15) | 4'($urandom_range(0, 15))));
    end
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
